// File: rtl/wisc_cache_pkg.sv
// ----------------------------------------------------------------------------
// wisc_cache_pkg
// Shared cache definitions for the instruction cache (and later the D-cache).
//   LINES / WORDS    : default geometry (lines per cache, 16-bit words per line)
//   OFF_W/IDX_W/TAG_W: address split widths derived from the geometry
//   icache_state_t   : fill controller states
//   line_t           : one cache line, word 0 in the least significant bits
// ----------------------------------------------------------------------------
package wisc_cache_pkg;

    localparam int LINES  = 8;
    localparam int WORDS  = 4;
    localparam int OFF_W  = $clog2(WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = 16 - IDX_W - OFF_W;
    localparam int LINE_W = 16 * WORDS;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    typedef logic [WORDS-1:0][15:0] line_t;

endpackage

// File: rtl/icache_array.sv
// ----------------------------------------------------------------------------
// icache_array
// Valid/tag/data storage for a direct-mapped cache.
//   clk, rst     : clock and synchronous active-high reset (clears valid bits)
//   rdIdx_i      : combinational read index
//   rdValid_o    : valid bit of the addressed line
//   rdTag_o      : stored tag of the addressed line
//   rdLine_o     : stored data of the addressed line (word 0 in the LSBs)
//   we_i         : write enable; installs tag/line and sets valid at the edge
//   wrIdx_i      : write index
//   wrTag_i      : tag to install
//   wrLine_i     : line data to install
//   invAll_i     : clear every valid bit at the edge; a simultaneous write
//                  still leaves its own line valid
// ----------------------------------------------------------------------------
module icache_array #(
    parameter int LINES = 8,
    parameter int WORDS = 4,
    parameter int IDX_W = 3,
    parameter int TAG_W = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     rdIdx_i,
    output logic                 rdValid_o,
    output logic [TAG_W-1:0]     rdTag_o,
    output logic [16*WORDS-1:0]  rdLine_o,
    input  logic                 we_i,
    input  logic [IDX_W-1:0]     wrIdx_i,
    input  logic [TAG_W-1:0]     wrTag_i,
    input  logic [16*WORDS-1:0]  wrLine_i,
    input  logic                 invAll_i
);

    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [16*WORDS-1:0] data_q [LINES];

    // Valid bits are the only reset state. The write is applied after the
    // invalidate so the line being filled survives a same-cycle invalidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (invAll_i) begin
                valid_q <= '0;
            end
            if (we_i) begin
                valid_q[wrIdx_i] <= 1'b1;
            end
        end
    end

    // Tag and data are plain storage; their contents only matter once the
    // matching valid bit is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wrIdx_i]  <= wrTag_i;
            data_q[wrIdx_i] <= wrLine_i;
        end
    end

    assign rdValid_o = valid_q[rdIdx_i];
    assign rdTag_o   = tag_q[rdIdx_i];
    assign rdLine_o  = data_q[rdIdx_i];

endmodule

// File: rtl/icache_fill_ctrl.sv
// ----------------------------------------------------------------------------
// icache_fill_ctrl
// Direct-mapped read-only instruction cache with a miss-fill state machine.
//   clk, rst    : clock and synchronous active-high reset
//   fetch_req   : IF stage requests the instruction at fetch_addr
//   fetch_addr  : 16-bit word address (PC)
//   inv         : invalidate all lines at the next edge
//   instr       : instruction word, zero whenever instr_valid is low
//   instr_valid : instr holds a hit this cycle (same-cycle hit path)
//   stall       : IF must hold its PC
//   mem_re      : line read request, high for the whole fill
//   mem_addr    : line-aligned address of the line being filled
//   mem_rdata   : returned line, word 0 in the LSBs
//   mem_rdy     : one-cycle pulse qualifying mem_rdata
// ----------------------------------------------------------------------------
module icache_fill_ctrl #(
    parameter int LINES = wisc_cache_pkg::LINES,
    parameter int WORDS = wisc_cache_pkg::WORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_req,
    input  logic [15:0]          fetch_addr,
    input  logic                 inv,
    output logic [15:0]          instr,
    output logic                 instr_valid,
    output logic                 stall,
    output logic                 mem_re,
    output logic [15:0]          mem_addr,
    input  logic [16*WORDS-1:0]  mem_rdata,
    input  logic                 mem_rdy
);

    import wisc_cache_pkg::*;

    localparam int OFF_L = $clog2(WORDS);
    localparam int IDX_L = $clog2(LINES);
    localparam int TAG_L = 16 - IDX_L - OFF_L;

    icache_state_t state_q, state_d;
    logic [15:0]   missAddr_q, missAddr_d;

    logic [OFF_L-1:0]    fetchOff;
    logic [IDX_L-1:0]    fetchIdx;
    logic [TAG_L-1:0]    fetchTag;
    logic                rdValid;
    logic [TAG_L-1:0]    rdTag;
    logic [16*WORDS-1:0] rdLine;
    logic [15:0]         hitWord;
    logic                hit;
    logic                arrWe;

    assign fetchOff = fetch_addr[OFF_L-1:0];
    assign fetchIdx = fetch_addr[OFF_L +: IDX_L];
    assign fetchTag = fetch_addr[15 -: TAG_L];

    // Fills always target the latched miss address, never the live PC, so a
    // PC that wanders during the fill cannot corrupt the installed line.
    icache_array #(
        .LINES (LINES),
        .WORDS (WORDS),
        .IDX_W (IDX_L),
        .TAG_W (TAG_L)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rdIdx_i   (fetchIdx),
        .rdValid_o (rdValid),
        .rdTag_o   (rdTag),
        .rdLine_o  (rdLine),
        .we_i      (arrWe),
        .wrIdx_i   (missAddr_q[OFF_L +: IDX_L]),
        .wrTag_i   (missAddr_q[15 -: TAG_L]),
        .wrLine_i  (mem_rdata),
        .invAll_i  (inv)
    );

    assign hit     = rdValid && (rdTag == fetchTag);
    assign hitWord = rdLine[{fetchOff, 4'b0000} +: 16];

    // State and miss-address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            missAddr_q <= '0;
        end else begin
            state_q    <= state_d;
            missAddr_q <= missAddr_d;
        end
    end

    // Lookup in IDLE is purely combinational; a miss latches the aligned
    // line address and parks in FILL until the memory pulses mem_rdy.
    // The array write is suppressed under reset so a late fill cannot land.
    always_comb begin
        state_d     = state_q;
        missAddr_d  = missAddr_q;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        stall       = 1'b0;
        arrWe       = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_req) begin
                    if (hit) begin
                        instr_valid = 1'b1;
                        instr       = hitWord;
                    end else begin
                        stall      = 1'b1;
                        missAddr_d = {fetch_addr[15:OFF_L], {OFF_L{1'b0}}};
                        state_d    = FILL;
                    end
                end
            end
            FILL: begin
                stall = 1'b1;
                if (mem_rdy) begin
                    arrWe   = !rst;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_re   = (state_q == FILL);
    assign mem_addr = missAddr_q;

endmodule
